// File: rtl/ex_stage_if.sv
// Decode/hazard <-> execute bundle for ex_stage. With EX_FORWARD_EN defined it also carries
// the forwarding selects and the writeback result.
interface ex_stage_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
);
  // Stall/flush: FlushE=1 loads a bubble on the next edge and wins over StallE; StallE=1 holds E.
  logic             StallE;
  logic             FlushE;
  logic [WIDTH-1:0] RD1D;
  logic [WIDTH-1:0] RD2D;
  logic [WIDTH-1:0] ImmExtD;
  logic [WIDTH-1:0] PCD;
  logic [WIDTH-1:0] PCPlus4D;
  logic [RADDR-1:0] RdD;
  logic [2:0]       ALUControlD;
  logic             ALUSrcD;
  logic             RegWriteD;
  logic             MemWriteD;
  logic             BranchD;
  logic             JumpD;
  logic [1:0]       ResultSrcD;
`ifdef EX_FORWARD_EN
  logic [1:0]       ForwardAE;
  logic [1:0]       ForwardBE;
  logic [WIDTH-1:0] ResultW;
`endif
  logic             ZeroE;
  logic             PCSrcE;
  logic [WIDTH-1:0] PCTargetE;
  logic [RADDR-1:0] RdE;
  logic [WIDTH-1:0] ALUResultM;
  logic [WIDTH-1:0] WriteDataM;
  logic [WIDTH-1:0] PCPlus4M;
  logic [RADDR-1:0] RdM;
  logic             RegWriteM;
  logic             MemWriteM;
  logic [1:0]       ResultSrcM;

  modport master (
    output StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, RdD, ALUControlD,
           ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD,
`ifdef EX_FORWARD_EN
    output ForwardAE, ForwardBE, ResultW,
`endif
    input  ZeroE, PCSrcE, PCTargetE, RdE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, ResultSrcM
  );

  modport slave (
    input  StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, RdD, ALUControlD,
           ALUSrcD, RegWriteD, MemWriteD, BranchD, JumpD, ResultSrcD,
`ifdef EX_FORWARD_EN
    input  ForwardAE, ForwardBE, ResultW,
`endif
    output ZeroE, PCSrcE, PCTargetE, RdE, ALUResultM, WriteDataM, PCPlus4M, RdM,
           RegWriteM, MemWriteM, ResultSrcM
  );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: D->E register, ALU and branch resolution, E->M register.
// Optional operand forwarding is enabled by defining EX_FORWARD_EN.
module ex_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input logic       clk,
  input logic       rst_n,
  ex_stage_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  typedef struct packed {
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] imm;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [RADDR-1:0] rd;
    logic [2:0]       alu_ctl;
    logic             alu_src;
    logic             reg_write;
    logic             mem_write;
    logic             branch;
    logic             jump;
    logic [1:0]       result_src;
  } de_t;

  typedef struct packed {
    logic [WIDTH-1:0] alu_result;
    logic [WIDTH-1:0] write_data;
    logic [WIDTH-1:0] pc_plus4;
    logic [RADDR-1:0] rd;
    logic             reg_write;
    logic             mem_write;
    logic [1:0]       result_src;
  } em_t;

  de_t              de_q;
  de_t              de_d;
  em_t              em_q;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] pre_b;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             ovf;
  logic             lt;
  logic [WIDTH-1:0] alu_result;

  always_comb begin
    de_d            = '0;
    de_d.rd1        = bus.RD1D;
    de_d.rd2        = bus.RD2D;
    de_d.imm        = bus.ImmExtD;
    de_d.pc         = bus.PCD;
    de_d.pc_plus4   = bus.PCPlus4D;
    de_d.rd         = bus.RdD;
    de_d.alu_ctl    = bus.ALUControlD;
    de_d.alu_src    = bus.ALUSrcD;
    de_d.reg_write  = bus.RegWriteD;
    de_d.mem_write  = bus.MemWriteD;
    de_d.branch     = bus.BranchD;
    de_d.jump       = bus.JumpD;
    de_d.result_src = bus.ResultSrcD;
  end

  // A bubble is the all-zero record, so Branch/Jump/RegWrite/MemWrite are cleared with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= '0;
    end else if (bus.FlushE) begin
      de_q <= '0;
    end else if (!bus.StallE) begin
      de_q <= de_d;
    end
  end

  always_comb begin
    src_a = de_q.rd1;
    pre_b = de_q.rd2;
`ifdef EX_FORWARD_EN
    case (bus.ForwardAE)
      2'b01:   src_a = bus.ResultW;
      2'b10:   src_a = em_q.alu_result;
      default: src_a = de_q.rd1;
    endcase
    case (bus.ForwardBE)
      2'b01:   pre_b = bus.ResultW;
      2'b10:   pre_b = em_q.alu_result;
      default: pre_b = de_q.rd2;
    endcase
`endif
    src_b = de_q.alu_src ? de_q.imm : pre_b;
  end

  // Signed less-than comes from the subtractor sign corrected by its overflow.
  always_comb begin
    sum  = src_a + src_b;
    diff = src_a + ~src_b + WIDTH'(1);
    ovf  = (src_a[MSB] ^ src_b[MSB]) & (src_a[MSB] ^ diff[MSB]);
    lt   = diff[MSB] ^ ovf;
    case (de_q.alu_ctl)
      3'b000:  alu_result = sum;
      3'b001:  alu_result = diff;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {{(WIDTH-1){1'b0}}, lt};
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_q <= '0;
    end else begin
      em_q.alu_result <= alu_result;
      em_q.write_data <= pre_b;
      em_q.pc_plus4   <= de_q.pc_plus4;
      em_q.rd         <= de_q.rd;
      em_q.reg_write  <= de_q.reg_write;
      em_q.mem_write  <= de_q.mem_write;
      em_q.result_src <= de_q.result_src;
    end
  end

  assign bus.ZeroE      = (alu_result == '0);
  assign bus.PCSrcE     = (de_q.branch & bus.ZeroE) | de_q.jump;
  assign bus.PCTargetE  = de_q.pc + de_q.imm;
  assign bus.RdE        = de_q.rd;
  assign bus.ALUResultM = em_q.alu_result;
  assign bus.WriteDataM = em_q.write_data;
  assign bus.PCPlus4M   = em_q.pc_plus4;
  assign bus.RdM        = em_q.rd;
  assign bus.RegWriteM  = em_q.reg_write;
  assign bus.MemWriteM  = em_q.mem_write;
  assign bus.ResultSrcM = em_q.result_src;
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: scoreboard of expected E->M records plus directed reset, stall,
// flush, branch and (with EX_FORWARD_EN) forwarding cases.
module tb_ex_stage;
  localparam int WIDTH = 32;
  localparam int RADDR = 5;
  localparam int EW    = 3*WIDTH + RADDR + 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [EW-1:0]    exp_q[$];
  logic             exp_zero;
  logic             exp_pcsrc;
  logic [WIDTH-1:0] exp_target;
  logic [RADDR-1:0] exp_rd_e;

  ex_stage_if #(.WIDTH(WIDTH), .RADDR(RADDR)) bus ();

  ex_stage #(.WIDTH(WIDTH), .RADDR(RADDR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model_alu(input logic [2:0] ctl,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
    case (ctl)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd5:    return ($signed(a) < $signed(b)) ? WIDTH'(1) : WIDTH'(0);
      default: return '0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  task automatic set_d(input logic [2:0] ctl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] imm, input logic [WIDTH-1:0] pc, input logic src,
                       input logic [RADDR-1:0] rd, input logic rw, input logic mw,
                       input logic br, input logic jp);
    bus.ALUControlD = ctl;
    bus.RD1D        = a;
    bus.RD2D        = b;
    bus.ImmExtD     = imm;
    bus.PCD         = pc;
    bus.PCPlus4D    = pc + 32'd4;
    bus.ALUSrcD     = src;
    bus.RdD         = rd;
    bus.RegWriteD   = rw;
    bus.MemWriteD   = mw;
    bus.BranchD     = br;
    bus.JumpD       = jp;
    bus.ResultSrcD  = rd[1:0];
  endtask

  // Drive one instruction, advance one edge, check E, and check M once the record arrives.
  task automatic issue(input logic [2:0] ctl, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] imm, input logic [WIDTH-1:0] pc, input logic src,
                       input logic [RADDR-1:0] rd, input logic rw, input logic mw,
                       input logic br, input logic jp);
    logic [WIDTH-1:0] res;
    logic [EW-1:0]    e;
    set_d(ctl, a, b, imm, pc, src, rd, rw, mw, br, jp);
    res = model_alu(ctl, a, src ? imm : b);
    exp_q.push_back({res, b, pc + 32'd4, rd, rd[1:0], rw, mw});
    exp_zero   = (res == 0);
    exp_pcsrc  = (br & exp_zero) | jp;
    exp_target = pc + imm;
    exp_rd_e   = rd;
    @(posedge clk);
    @(negedge clk);
    check("zero_e", EW'(bus.ZeroE), EW'(exp_zero));
    check("pcsrc_e", EW'(bus.PCSrcE), EW'(exp_pcsrc));
    check("pctarget_e", EW'(bus.PCTargetE), EW'(exp_target));
    check("rd_e", EW'(bus.RdE), EW'(exp_rd_e));
    if (exp_q.size() == 2) begin
      e = exp_q.pop_front();
      check("m_record", {bus.ALUResultM, bus.WriteDataM, bus.PCPlus4M, bus.RdM,
                         bus.ResultSrcM, bus.RegWriteM, bus.MemWriteM}, e);
    end
  endtask

  task automatic nop();
    issue(3'd0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.StallE = 1'b0;
    bus.FlushE = 1'b0;
`ifdef EX_FORWARD_EN
    bus.ForwardAE = 2'b00;
    bus.ForwardBE = 2'b00;
    bus.ResultW   = '0;
`endif
    set_d(3'd0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

    #2;
    check("rst_alu_m", EW'(bus.ALUResultM), '0);
    check("rst_regwrite_m", EW'(bus.RegWriteM), '0);
    check("rst_zero_e", EW'(bus.ZeroE), EW'(1));
    check("rst_pcsrc_e", EW'(bus.PCSrcE), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // 5 - 7 wraps to -2
    issue(3'd1, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sub_zero_e", EW'(bus.ZeroE), '0);
    nop();
    check("sub_5_7", EW'(bus.ALUResultM), EW'(32'hFFFF_FFFE));

    issue(3'd5, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(3'd5, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("slt_min_lt_1", EW'(bus.ALUResultM), EW'(1));
    issue(3'd6, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check("slt_max_lt_m1", EW'(bus.ALUResultM), EW'(0));
    nop();
    check("code_110", EW'(bus.ALUResultM), EW'(0));

    issue(3'd1, 32'd9, 32'd9, 32'hFFFF_FFF8, 32'd100, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("branch_pcsrc", EW'(bus.PCSrcE), EW'(1));
    check("branch_target", EW'(bus.PCTargetE), EW'(92));

    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      a = pick();
      b = ($urandom_range(0, 3) == 0) ? a : pick();
      issue(3'($urandom_range(0, 7)), a, b, $urandom(), $urandom(), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
    nop();
    nop();

    // Stall holds E for two edges while D keeps changing.
    exp_q.delete();
    issue(3'd0, 32'd11, 32'd22, 32'h40, 32'h200, 1'b0, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.StallE = 1'b1;
    set_d(3'd2, 32'h5, 32'h6, 32'h7, 32'h0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_rd_e", EW'(bus.RdE), EW'(9));
      check("stall_target_e", EW'(bus.PCTargetE), EW'(32'h240));
      check("stall_alu_m", EW'(bus.ALUResultM), EW'(33));
    end

    // Flush beats stall: bubble enters E, then reaches M.
    bus.FlushE = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("flush_rd_e", EW'(bus.RdE), '0);
    check("flush_pcsrc_e", EW'(bus.PCSrcE), '0);
    check("flush_zero_e", EW'(bus.ZeroE), EW'(1));
    check("flush_prev_regwrite_m", EW'(bus.RegWriteM), EW'(1));
    bus.FlushE = 1'b0;
    bus.StallE = 1'b0;
    set_d(3'd0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("flush_regwrite_m", EW'(bus.RegWriteM), '0);
    check("flush_memwrite_m", EW'(bus.MemWriteM), '0);

    // Asynchronous reset between edges.
    exp_q.delete();
    issue(3'd3, 32'h1234, 32'h00F0, 32'h10, 32'h300, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
    issue(3'd0, 32'h1, 32'h2, 32'h10, 32'h304, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_alu_m", EW'(bus.ALUResultM), '0);
    check("arst_wdata_m", EW'(bus.WriteDataM), '0);
    check("arst_rd_m", EW'(bus.RdM), '0);
    check("arst_regwrite_m", EW'(bus.RegWriteM), '0);
    check("arst_rd_e", EW'(bus.RdE), '0);
    check("arst_zero_e", EW'(bus.ZeroE), EW'(1));
    check("arst_pcsrc_e", EW'(bus.PCSrcE), '0);
    check("arst_target_e", EW'(bus.PCTargetE), '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    nop();

`ifdef EX_FORWARD_EN
    exp_q.delete();
    issue(3'd0, 32'd40, 32'd0, 32'd2, 32'd0, 1'b1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(3'd0, 32'd0, 32'd0, 32'd1, 32'd0, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fwd_prev_m", EW'(bus.ALUResultM), EW'(42));
    exp_q.delete();
    bus.ForwardAE = 2'b10;
    set_d(3'd0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("fwd_a_alu_m", EW'(bus.ALUResultM), EW'(43));
    bus.ForwardAE = 2'b00;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
